// File: rtl/aes_pkg.sv
// Shared AES constants and the ShiftRows byte-index tables used by the round stages.
// Byte i of a state is bits [(15-i)*8+7 -: 8]; bytes are column-major.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NB      = 4;
  localparam int AES_NBYTES  = AES_NB * AES_NB;

  // Output byte j is taken from input byte *_SR_IDX[j].
  localparam int INV_SR_IDX [AES_NBYTES] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
  localparam int FWD_SR_IDX [AES_NBYTES] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

  function automatic logic [AES_BYTE_W-1:0] state_byte(input logic [AES_STATE_W-1:0] s,
                                                      input int idx);
    return s[(AES_NBYTES-1-idx)*AES_BYTE_W +: AES_BYTE_W];
  endfunction

endpackage

// File: rtl/aes_inv_sr_perm.sv
// Combinational (Inv)ShiftRows byte permutation of one 128-bit AES state.
// Macro AES_SR_DIR_SEL_EN adds a dir input: 1 = forward map, 0 = inverse map.
module aes_inv_sr_perm
  import aes_pkg::*;
(
  input  logic [AES_STATE_W-1:0] state_in,
`ifdef AES_SR_DIR_SEL_EN
  input  logic                   dir,
`endif
  output logic [AES_STATE_W-1:0] state_out
);

  always_comb begin
    // NOTE: a default assignment first means no path leaves state_out unassigned, so no latch.
    state_out = '0;
    for (int j = 0; j < AES_NBYTES; j++) begin
`ifdef AES_SR_DIR_SEL_EN
      state_out[(AES_NBYTES-1-j)*AES_BYTE_W +: AES_BYTE_W] =
        state_byte(state_in, dir ? FWD_SR_IDX[j] : INV_SR_IDX[j]);
`else
      state_out[(AES_NBYTES-1-j)*AES_BYTE_W +: AES_BYTE_W] = state_byte(state_in, INV_SR_IDX[j]);
`endif
    end
  end

endmodule

// File: rtl/aes_inv_shift_rows_pipe.sv
// InvShiftRows pipeline stage: permute, then an output register backed by a one-entry skid.
// Macro AES_SR_DIR_SEL_EN adds dir_in to select the forward map per block.
module aes_inv_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [TAG_W-1:0]  tag_in,
`ifdef AES_SR_DIR_SEL_EN
  input  logic              dir_in,
`endif
  input  logic              flush,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] data_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic [CNT_W-1:0]  blk_cnt
);

  if (DATA_W != AES_STATE_W) begin : g_width_check
    $error("aes_inv_shift_rows_pipe: DATA_W must be 128");
  end

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [TAG_W-1:0]  skid_tag;
  logic [DATA_W-1:0] perm_data;
  logic              accept;
  logic              or_load;

  assign ready_in = ~skid_valid;
  assign accept   = valid_in & ready_in;
  assign or_load  = ~valid_out | ready_out;

  aes_inv_sr_perm u_perm (
    .state_in  (data_in),
`ifdef AES_SR_DIR_SEL_EN
    .dir       (dir_in),
`endif
    .state_out (perm_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      tag_out    <= '0;
      skid_valid <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (accept && !flush) blk_cnt <= blk_cnt + CNT_W'(1);

      if (flush) begin
        valid_out  <= 1'b0;
        skid_valid <= 1'b0;
      end else if (or_load) begin
        // A full skid holds the older block, so it drains before any new input.
        if (skid_valid) begin
          data_out   <= skid_data;
          tag_out    <= skid_tag;
          valid_out  <= 1'b1;
          skid_valid <= 1'b0;
        end else if (accept) begin
          data_out  <= perm_data;
          tag_out   <= tag_in;
          valid_out <= 1'b1;
        end else begin
          valid_out <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
      end
    end
  end

  // NOTE: skid payload needs no reset; skid_valid qualifies it and is itself reset.
  always_ff @(posedge clk) begin
    if (accept && !flush && !or_load) begin
      skid_data <= perm_data;
      skid_tag  <= tag_in;
    end
  end

endmodule

// File: tb/tb_aes_inv_shift_rows_pipe.sv
// Self-checking bench for aes_inv_shift_rows_pipe with a scoreboard of expected output blocks.
// Build with AES_SR_DIR_SEL_EN defined to also cover the direction select.
module tb_aes_inv_shift_rows_pipe;

  localparam int DATA_W = 128;
  localparam int TAG_W  = 4;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } sb_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              valid_in = 1'b0;
  logic              ready_in;
  logic [DATA_W-1:0] data_in = '0;
  logic [TAG_W-1:0]  tag_in = '0;
  logic              dir_in = 1'b0;
  logic              flush = 1'b0;
  logic              valid_out;
  logic              ready_out = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic [TAG_W-1:0]  tag_out;
  logic [CNT_W-1:0]  blk_cnt;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  sb_t sb[$];

  localparam logic [DATA_W-1:0] IDENT   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [DATA_W-1:0] INV_ID  = 128'h000d0a0704010e0b0805020f0c090603;
  localparam logic [DATA_W-1:0] FWD_ID  = 128'h00050a0f04090e03080d02070c01060b;

  aes_inv_shift_rows_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .tag_in    (tag_in),
`ifdef AES_SR_DIR_SEL_EN
    .dir_in    (dir_in),
`endif
    .flush     (flush),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .tag_out   (tag_out),
    .blk_cnt   (blk_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Row r is rotated right by r (inverse) or left by r (forward).
  function automatic logic [DATA_W-1:0] ref_shift(input logic [DATA_W-1:0] s, input logic fwd);
    logic [DATA_W-1:0] r;
    int src_c;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        src_c = fwd ? (c + row) % 4 : (c - row + 4) % 4;
        r[(15 - (4*c + row))*8 +: 8] = s[(15 - (4*src_c + row))*8 +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard monitor: compare on output handshake, push on accept, check hold stability.
  logic              prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [TAG_W-1:0]  prev_tag;
  always @(negedge clk) begin
    sb_t exp;
    if (!reset) begin
      sb.delete();
      exp_cnt   = '0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && valid_out) begin
        checks++;
        if (data_out !== prev_data || tag_out !== prev_tag) begin
          errors++;
          $display("FAIL hold_stable: got %h/%h want %h/%h", data_out, tag_out, prev_data, prev_tag);
        end
      end
      if (valid_out && ready_out) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got %h tag %h, none expected", data_out, tag_out);
        end else begin
          exp = sb.pop_front();
          delivered++;
          if (data_out !== exp.data || tag_out !== exp.tag) begin
            errors++;
            $display("FAIL sb_block: got %h/%h want %h/%h", data_out, tag_out, exp.data, exp.tag);
          end
        end
      end
      prev_hold = valid_out && !ready_out && !flush;
      prev_data = data_out;
      prev_tag  = tag_out;
      if (flush) begin
        sb.delete();
      end else if (valid_in && ready_in) begin
        sb.push_back('{data: ref_shift(data_in, dir_in), tag: tag_in});
        exp_cnt = exp_cnt + 1'b1;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== '0 || tag_out !== '0 || ready_in !== 1'b1 || blk_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%b d=%h t=%h rdy=%b cnt=%0d want 0/0/0/1/0",
               valid_out, data_out, tag_out, ready_in, blk_cnt);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: v=%b rdy=%b want 0/1", valid_out, ready_in);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    ready_out = 1'b1; valid_in = 1'b1; data_in = IDENT; tag_in = 4'd3; dir_in = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || data_out !== INV_ID || tag_out !== 4'd3 || blk_cnt !== 4'd1) begin
      errors++;
      $display("FAIL single: v=%b d=%h t=%0d cnt=%0d want 1/%h/3/1", valid_out, data_out, tag_out,
               blk_cnt, INV_ID);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_drain: v=%b pending=%0d want 0/0", valid_out, sb.size());
    end
  endtask

  task automatic test_stream();
    int d0;
    logic [CNT_W-1:0] want;
    d0 = delivered;
    want = exp_cnt + 4'd8;
    ready_out = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_in = 1'b1; data_in = rand_block(); tag_in = TAG_W'(i);
      checks++;
      if (ready_in !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready: beat %0d ready_in=%b want 1", i, ready_in);
      end
      @(posedge clk); #1;
      checks++;
      if (valid_out !== 1'b1) begin
        errors++;
        $display("FAIL stream_valid: beat %0d valid_out=%b want 1", i, valid_out);
      end
    end
    valid_in = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (delivered - d0 != 8 || blk_cnt !== want || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL stream_total: delivered=%0d cnt=%0d v=%b want 8/%0d/0", delivered - d0, blk_cnt,
               valid_out, want);
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] a, b, c;
    logic [CNT_W-1:0]  cnt0;
    bit got_c;
    a = rand_block(); b = rand_block(); c = rand_block();
    cnt0 = exp_cnt;
    ready_out = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b1; data_in = a; tag_in = 4'd1;
    @(posedge clk); #1;
    data_in = b; tag_in = 4'd2;
    @(posedge clk); #1;
    data_in = c; tag_in = 4'd3;
    checks++;
    if (ready_in !== 1'b0 || valid_out !== 1'b1 || data_out !== ref_shift(a, 1'b0) || tag_out !== 4'd1) begin
      errors++;
      $display("FAIL bp_full: rdy=%b v=%b d=%h t=%0d want 0/1/%h/1", ready_in, valid_out, data_out,
               tag_out, ref_shift(a, 1'b0));
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ready_in !== 1'b0 || data_out !== ref_shift(a, 1'b0)) begin
        errors++;
        $display("FAIL bp_stall: cycle %0d rdy=%b d=%h want 0/%h", k, ready_in, data_out, ref_shift(a, 1'b0));
      end
    end
    checks++;
    if (blk_cnt !== cnt0 + 4'd2) begin
      errors++;
      $display("FAIL bp_count: cnt=%0d want %0d", blk_cnt, cnt0 + 4'd2);
    end
    ready_out = 1'b1;
    got_c = 1'b0;
    for (int k = 0; k < 10 && !got_c; k++) begin
      if (ready_in === 1'b1) got_c = 1'b1;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    checks++;
    if (!got_c) begin
      errors++;
      $display("FAIL bp_third_accept: third block not accepted within 10 cycles");
    end
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1'b0 || sb.size() != 0 || blk_cnt !== cnt0 + 4'd3) begin
      errors++;
      $display("FAIL bp_drain: v=%b pending=%0d cnt=%0d want 0/0/%0d", valid_out, sb.size(), blk_cnt,
               cnt0 + 4'd3);
    end
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] cnt0;
    int d0;
    cnt0 = exp_cnt;
    ready_out = 1'b0;
    valid_in = 1'b1; data_in = rand_block(); tag_in = 4'd4;
    @(posedge clk); #1;
    data_in = rand_block(); tag_in = 4'd5;
    @(posedge clk); #1;
    checks++;
    if (ready_in !== 1'b0 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL flush_fill: rdy=%b v=%b want 0/1", ready_in, valid_out);
    end
    flush = 1'b1; data_in = rand_block(); tag_in = 4'd6;
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b0;
    d0 = delivered;
    checks++;
    if (valid_out !== 1'b0 || ready_in !== 1'b1 || blk_cnt !== cnt0 + 4'd2) begin
      errors++;
      $display("FAIL flush_full: v=%b rdy=%b cnt=%0d want 0/1/%0d", valid_out, ready_in, blk_cnt,
               cnt0 + 4'd2);
    end
    ready_out = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_deliver: valid_out=%b want 0", valid_out);
      end
    end
    valid_in = 1'b1; flush = 1'b1; data_in = rand_block(); tag_in = 4'd7;
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1'b0 || blk_cnt !== cnt0 + 4'd2 || delivered != d0) begin
      errors++;
      $display("FAIL flush_drop_input: v=%b cnt=%0d delivered=%0d want 0/%0d/%0d", valid_out, blk_cnt,
               delivered, cnt0 + 4'd2, d0);
    end
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    ready_out = 1'b1;
    for (int i = 0; i < 17; i++) begin
      valid_in = 1'b1; data_in = rand_block(); tag_in = TAG_W'(i);
      @(posedge clk); #1;
      if (i == 15) begin
        checks++;
        if (blk_cnt !== 4'd0) begin
          errors++;
          $display("FAIL wrap_zero: cnt=%0d want 0 after 16 accepts", blk_cnt);
        end
      end
    end
    valid_in = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (blk_cnt !== 4'd1) begin
      errors++;
      $display("FAIL wrap_17: cnt=%0d want 1", blk_cnt);
    end
  endtask

  task automatic test_async_reset();
    ready_out = 1'b0;
    valid_in = 1'b1; data_in = rand_block(); tag_in = 4'd9;
    @(posedge clk); #1;
    data_in = rand_block(); tag_in = 4'd10;
    @(posedge clk); #1;
    valid_in = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== '0 || tag_out !== '0 || ready_in !== 1'b1 || blk_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset: v=%b d=%h t=%h rdy=%b cnt=%0d want 0/0/0/1/0",
               valid_out, data_out, tag_out, ready_in, blk_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    ready_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL async_reset_lost: v=%b pending=%0d want 0/0", valid_out, sb.size());
    end
  endtask

`ifdef AES_SR_DIR_SEL_EN
  task automatic test_dir();
    ready_out = 1'b1;
    valid_in = 1'b1; data_in = IDENT; tag_in = 4'd5; dir_in = 1'b1;
    @(posedge clk); #1;
    data_in = FWD_ID; dir_in = 1'b0;
    checks++;
    if (data_out !== FWD_ID || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL dir_forward: got %h want %h", data_out, FWD_ID);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    checks++;
    if (data_out !== IDENT || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL dir_roundtrip: got %h want %h", data_out, IDENT);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap();
    test_async_reset();
`ifdef AES_SR_DIR_SEL_EN
    test_dir();
`endif
    ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d expected blocks never delivered", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
